// File: rtl/sm3_msg_src.sv
// rtl/sm3_msg_src.sv - SM3 message word source: host word FIFO feeding the hash core, with end-of-message sequencing.
// Optional byte counter output enabled by SM3_MSG_SRC_BYTE_CNT_EN.
module sm3_msg_src #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_vld_byte,
  input  logic        wr_lst,
  output logic        wr_full,
  output logic [31:0] msg_inpt_d,
  output logic [3:0]  msg_inpt_vld_byte,
  output logic        msg_inpt_vld,
  output logic        msg_inpt_lst,
  input  logic        msg_inpt_rdy,
  input  logic        cmprss_otpt_vld,
  output logic        busy,
  output logic        done,
  output logic        err_ovf
`ifdef SM3_MSG_SRC_BYTE_CNT_EN
  ,
  output logic [60:0] msg_byte_num
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, LAST, WAIT_RES} state_t;

  state_t          state_q;
  logic [31:0]     data_q [FIFO_DEPTH];
  logic [3:0]      mask_q [FIFO_DEPTH];
  logic            lst_q  [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic            lst_seen_q;
  logic            done_q;
  logic            err_q;
  logic            fifo_full;
  logic            push, pop;

  // Full is decided from registered count only, so a pop frees its slot one cycle later.
  assign fifo_full = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign wr_full   = fifo_full | lst_seen_q | (state_q == LAST) | (state_q == WAIT_RES);
  assign push      = wr_en & ~wr_full;

  assign msg_inpt_vld      = (state_q == SEND) && (cnt_q != '0);
  assign msg_inpt_d        = msg_inpt_vld ? data_q[rd_ptr_q] : 32'h0;
  assign msg_inpt_vld_byte = msg_inpt_vld ? mask_q[rd_ptr_q] : 4'h0;
  assign msg_inpt_lst      = (state_q == LAST);
  assign pop               = msg_inpt_vld & msg_inpt_rdy;

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err_ovf = err_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset: every read is gated by the registered count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= wr_data;
      mask_q[wr_ptr_q] <= wr_vld_byte;
      lst_q[wr_ptr_q]  <= wr_lst;
    end
  end

`ifdef SM3_MSG_SRC_BYTE_CNT_EN
  logic [60:0] byte_cnt_q;
  logic [60:0] pop_bytes;

  assign pop_bytes    = 61'(msg_inpt_vld_byte[3]) + 61'(msg_inpt_vld_byte[2])
                      + 61'(msg_inpt_vld_byte[1]) + 61'(msg_inpt_vld_byte[0]);
  assign msg_byte_num = byte_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
    end else if ((state_q == IDLE) && push) begin
      byte_cnt_q <= '0;
    end else if (pop) begin
      byte_cnt_q <= byte_cnt_q + pop_bytes;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      lst_seen_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_d;
      if (wr_en && wr_full) err_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && wr_lst) lst_seen_q <= 1'b1;

      case (state_q)
        IDLE:     if (push) state_q <= SEND;
        SEND:     if (pop && lst_q[rd_ptr_q]) state_q <= LAST;
        LAST:     state_q <= WAIT_RES;
        WAIT_RES: begin
          if (cmprss_otpt_vld) begin
            state_q    <= IDLE;
            done_q     <= 1'b1;
            lst_seen_q <= 1'b0;
          end
        end
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_msg_src.sv
// tb/tb_sm3_msg_src.sv - directed/randomized bench for sm3_msg_src with a queue-based reference model.
module tb_sm3_msg_src;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_vb = '0;
  logic        wr_lst = 1'b0;
  logic        rdy = 1'b0;
  logic        cmp = 1'b0;
  logic        wr_full, vld, lst, busy, done, err;
  logic [31:0] d;
  logic [3:0]  vb;
`ifdef SM3_MSG_SRC_BYTE_CNT_EN
  logic [60:0] byte_num;
`endif

  sm3_msg_src #(.FIFO_DEPTH(D)) dut (
    .clk               (clk),
    .rst               (rst),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .wr_vld_byte       (wr_vb),
    .wr_lst            (wr_lst),
    .wr_full           (wr_full),
    .msg_inpt_d        (d),
    .msg_inpt_vld_byte (vb),
    .msg_inpt_vld      (vld),
    .msg_inpt_lst      (lst),
    .msg_inpt_rdy      (rdy),
    .cmprss_otpt_vld   (cmp),
    .busy              (busy),
    .done              (done),
    .err_ovf           (err)
`ifdef SM3_MSG_SRC_BYTE_CNT_EN
    ,
    .msg_byte_num      (byte_num)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lst;
    logic [3:0]  m;
    logic [31:0] d;
  } wd_t;

  int      tests = 0;
  int      failed = 0;
  wd_t     q[$];
  bit      lst_acc, pulse_now, waiting, done_now, in_msg, err_m;
  int      xfers;
  longint  bytes;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pc(input logic [3:0] m);
    int n = 0;
    for (int i = 0; i < 4; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic logic [3:0] rmask();
    case ($urandom_range(0, 3))
      0:       return 4'hF;
      1:       return 4'hE;
      2:       return 4'hC;
      default: return 4'h8;
    endcase
  endfunction

  function automatic bit pred_full();
    return (q.size() == D) || lst_acc;
  endfunction

  task automatic model_clear();
    q.delete();
    lst_acc = 0; pulse_now = 0; waiting = 0; done_now = 0; in_msg = 0; err_m = 0;
    xfers = 0; bytes = 0;
  endtask

  // One clock cycle: compare outputs with the model, then advance the model over the edge.
  task automatic cyc();
    wd_t f;
    bit  exp_full, np, nd;
    exp_full = pred_full();
    f = (q.size() != 0) ? q[0] : '0;
    check("wr_full", wr_full, exp_full);
    check("vld", vld, q.size() != 0);
    check("data", d, f.d);
    check("mask", vb, f.m);
    check("lst", lst, pulse_now);
    check("busy", busy, in_msg);
    check("done", done, done_now);
    check("err_ovf", err, err_m);
`ifdef SM3_MSG_SRC_BYTE_CNT_EN
    check("byte_num", byte_num, bytes);
`endif
    np = 0; nd = 0;
    if (q.size() != 0 && rdy) begin
      f = q.pop_front();
      xfers++;
      bytes += pc(f.m);
      if (f.lst) np = 1;
    end
    if (waiting && cmp) begin
      waiting = 0; in_msg = 0; lst_acc = 0; nd = 1;
    end
    if (pulse_now) waiting = 1;
    if (wr_en) begin
      if (!exp_full) begin
        if (!in_msg) bytes = 0;
        q.push_back('{lst: wr_lst, m: wr_vb, d: wr_data});
        in_msg = 1;
        if (wr_lst) lst_acc = 1;
      end else begin
        err_m = 1;
      end
    end
    pulse_now = np;
    done_now  = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit en, input logic [31:0] dat, input logic [3:0] m,
                     input bit l, input bit r, input bit c);
    wr_en = en; wr_data = dat; wr_vb = m; wr_lst = l; rdy = r; cmp = c;
    cyc();
  endtask

  task automatic idle(input bit r, input int n);
    for (int i = 0; i < n; i++) drv(0, '0, '0, 0, r, 0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    wr_en = 0; rdy = 0; cmp = 0; wr_lst = 0;
    #1;
    check("rst_vld", vld, 1'b0);
    check("rst_data", d, 32'h0);
    check("rst_mask", vb, 4'h0);
    check("rst_lst", lst, 1'b0);
    check("rst_full", wr_full, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_done", done, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] vals[16];
  int          idx;
  bit          en;

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("init_vld", vld, 1'b0);
    check("init_full", wr_full, 1'b0);
    check("init_lst", lst, 1'b0);
    check("init_busy", busy, 1'b0);
    check("init_done", done, 1'b0);
    check("init_err", err, 1'b0);
    rst = 1'b0;
    idle(0, 1);

    // result strobe while idle must be ignored
    drv(0, '0, '0, 0, 1, 1);
    idle(1, 2);

    // single-word message
    xfers = 0;
    drv(1, 32'h61626380, 4'hF, 1, 1, 0);
    idle(1, 3);
    drv(0, '0, '0, 0, 1, 1);
    idle(1, 2);
    check("single_xfers", xfers, 1);

    // overflow with core stalled
    xfers = 0;
    for (int i = 0; i < 6; i++) drv(1, $urandom, rmask(), 0, 0, 0);
    check("ovf_sticky", err, 1'b1);
    idle(1, 8);
    check("ovf_xfers", xfers, 4);
    check("ovf_drained", q.size(), 0);
    do_reset();

    // 16-word stream with toggling ready, final word mask 1100
    for (int i = 0; i < 16; i++) vals[i] = $urandom;
    idx = 0;
    for (int c = 0; c < 200 && (idx < 16 || q.size() > 0); c++) begin
      en = (idx < 16) && !pred_full();
      drv(en, en ? vals[idx] : 32'h0, (idx == 15) ? 4'hC : 4'hF, idx == 15, c % 2 == 0, 0);
      if (en) idx++;
    end
    check("stream_xfers", xfers, 16);
    check("stream_drained", q.size(), 0);
`ifdef SM3_MSG_SRC_BYTE_CNT_EN
    check("stream_bytes", byte_num, 61'd62);
`endif
    idle(1, 2);
    drv(0, '0, '0, 0, 1, 1);
    idle(1, 2);

    // reset during SEND with three words queued
    drv(1, $urandom, rmask(), 0, 0, 0);
    drv(1, $urandom, rmask(), 0, 0, 0);
    drv(1, $urandom, rmask(), 0, 0, 0);
    check("pre_rst_busy", busy, 1'b1);
    do_reset();
    idle(1, 2);
    drv(1, $urandom, rmask(), 0, 0, 0);
    drv(1, $urandom, rmask(), 1, 0, 0);
    idle(1, 5);
    check("post_rst_xfers", xfers, 2);
    drv(0, '0, '0, 0, 1, 1);
    idle(1, 2);

    // write after last word is rejected and leaves queue intact
    xfers = 0;
    drv(1, $urandom, rmask(), 0, 0, 0);
    drv(1, $urandom, rmask(), 1, 0, 0);
    drv(1, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("late_wr_err", err, 1'b1);
    idle(1, 6);
    check("late_wr_xfers", xfers, 2);
    drv(0, '0, '0, 0, 1, 1);
    idle(1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
